// File: rtl/core_pipe_fetch_req_pkg.sv
// Shared fetch-front-end constants and the inflight tracker entry layout.
// The buffer capacity here is the same one the fetch data buffer is sized from.
package core_pipe_fetch_req_pkg;

    localparam int FETCH_BUF_BYTES = 12;
    localparam int FETCH_OFF_W     = 2;

    typedef struct packed {
        logic                   discard;
        logic [FETCH_OFF_W-1:0] off;
    } fetch_inflight_t;

    // Bytes delivered by a request starting at halfword offset off within a doubleword
    function automatic logic [3:0] fetch_nbytes(input logic [FETCH_OFF_W-1:0] off);
        return 4'd8 - {1'b0, off, 1'b0};
    endfunction

endpackage

// File: rtl/core_pipe_fetch_req_fifo.sv
// In-order tracker of granted, unanswered fetch requests.
// A mark-all-discard also tags an entry pushed in the same cycle.
module core_pipe_fetch_req_fifo
    import core_pipe_fetch_req_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            push,
    input  fetch_inflight_t push_entry,
    input  logic            pop,
    input  logic            discard_all,
    output fetch_inflight_t head,
    output logic [CW-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    fetch_inflight_t entries [DEPTH];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_inflight_t entry_reg;

            always_ff @(posedge g_clk) begin
                if (!g_resetn) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg.off     <= push_entry.off;
                    entry_reg.discard <= push_entry.discard | discard_all;
                end else if (discard_all) begin
                    entry_reg.discard <= 1'b1;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    // A response with nothing outstanding means the memory side lost sync
    always_ff @(posedge g_clk) begin
        if (g_resetn && pop) assert (count_reg != '0);
    end

    assign head  = entries[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/core_pipe_fetch_req.sv
// Fetch request issue, response alignment and redirect handling ahead of the fetch buffer.
// Optional CORE_FETCH_ERR_HALT_EN: stop issuing after an error response until the next redirect.
module core_pipe_fetch_req
    import core_pipe_fetch_req_pkg::*;
#(
    parameter logic [63:0] PC_RESET     = 64'h0000_0000_8000_0000,
    parameter int          BUF_BYTES    = FETCH_BUF_BYTES,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cf_req,
    input  logic [63:0] cf_target,
    output logic        cf_ack,
    output logic        imem_req,
    input  logic        imem_gnt,
    output logic [63:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [63:0] imem_rsp_rdata,
    input  logic        imem_rsp_error,
    input  logic [4:0]  buf_depth,
    output logic        buf_flush,
    output logic [63:0] buf_data,
    output logic        buf_error,
    output logic        buf_fill_2,
    output logic        buf_fill_4,
    output logic        buf_fill_6,
    output logic        buf_fill_8
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);

    logic [63:0]            fetch_ptr_reg, fetch_ptr_next;
    logic [6:0]             inflight_bytes_reg, inflight_bytes_next;
    logic                   req_hold_reg;
    logic                   halt_reg;
    logic [FETCH_OFF_W-1:0] off;
    logic [3:0]             nb, rsp_nb;
    logic [6:0]             fetch_room;
    logic                   issue_ok, push, rsp_live;
    fetch_inflight_t        head;
    logic [CW-1:0]          inflight_cnt;

    assign off        = fetch_ptr_reg[2:1];
    assign nb         = fetch_nbytes(off);
    assign imem_addr  = {fetch_ptr_reg[63:3], 3'b000};
    assign fetch_room = 7'(buf_depth) + inflight_bytes_reg + 7'(nb);
    assign issue_ok   = (int'(inflight_cnt) < MAX_INFLIGHT) && (fetch_room <= 7'(BUF_BYTES));

    // Once raised, the request holds until granted regardless of buffer movement
    assign imem_req  = g_resetn & (req_hold_reg | (issue_ok & ~halt_reg));
    assign cf_ack    = g_resetn & cf_req & ~(imem_req & ~imem_gnt);
    assign buf_flush = cf_ack;
    assign push      = imem_req & imem_gnt;

    core_pipe_fetch_req_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .CW    (CW)
    ) u_fifo (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .push        (push),
        .push_entry  ('{discard: 1'b0, off: off}),
        .pop         (imem_rsp_valid),
        .discard_all (cf_ack),
        .head        (head),
        .count       (inflight_cnt)
    );

    assign rsp_live   = g_resetn & imem_rsp_valid & ~head.discard & ~cf_ack;
    assign rsp_nb     = fetch_nbytes(head.off);
    assign buf_data   = rsp_live ? (imem_rsp_rdata >> {head.off, 4'b0000}) : '0;
    assign buf_error  = rsp_live & imem_rsp_error;
    assign buf_fill_8 = rsp_live & (head.off == 2'd0);
    assign buf_fill_6 = rsp_live & (head.off == 2'd1);
    assign buf_fill_4 = rsp_live & (head.off == 2'd2);
    assign buf_fill_2 = rsp_live & (head.off == 2'd3);

`ifdef CORE_FETCH_ERR_HALT_EN
    always_ff @(posedge g_clk) begin
        if (!g_resetn)                       halt_reg <= 1'b0;
        else if (cf_ack)                     halt_reg <= 1'b0;
        else if (rsp_live && imem_rsp_error) halt_reg <= 1'b1;
    end
`else
    assign halt_reg = 1'b0;
`endif

    // Discarded entries carry no byte credit, so a redirect simply zeroes the tally
    always_comb begin
        fetch_ptr_next      = fetch_ptr_reg;
        inflight_bytes_next = inflight_bytes_reg;
        if (cf_ack) begin
            fetch_ptr_next      = {cf_target[63:1], 1'b0};
            inflight_bytes_next = '0;
        end else begin
            if (push) fetch_ptr_next = imem_addr + 64'd8;
            inflight_bytes_next = inflight_bytes_reg
                                + (push     ? 7'(nb)     : 7'd0)
                                - (rsp_live ? 7'(rsp_nb) : 7'd0);
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            fetch_ptr_reg      <= PC_RESET;
            inflight_bytes_reg <= '0;
            req_hold_reg       <= 1'b0;
        end else begin
            fetch_ptr_reg      <= fetch_ptr_next;
            inflight_bytes_reg <= inflight_bytes_next;
            req_hold_reg       <= imem_req & ~imem_gnt;
        end
    end

endmodule

// File: tb/tb_core_pipe_fetch_req.sv
// Directed vector table for the fetch request front end, then random traffic
// against a queue-based reference model with an in-order memory responder.
module tb_core_pipe_fetch_req;

    localparam logic [63:0] PC = 64'h0000_0000_8000_0000;
`ifdef CORE_FETCH_ERR_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam logic [3:0] F0 = 4'b0000, F8 = 4'b1000, F6 = 4'b0100, F4 = 4'b0010, F2 = 4'b0001;
    localparam logic [63:0] JUNK = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        g_clk = 1'b0, g_resetn = 1'b0;
    logic        cf_req = 1'b0, cf_ack;
    logic [63:0] cf_target = '0;
    logic        imem_req, imem_gnt = 1'b0;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid = 1'b0, imem_rsp_error = 1'b0;
    logic [63:0] imem_rsp_rdata = '0;
    logic [4:0]  buf_depth = '0;
    logic        buf_flush, buf_error;
    logic [63:0] buf_data;
    logic        buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8;

    always #5 g_clk = ~g_clk;

    core_pipe_fetch_req dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .cf_req         (cf_req),
        .cf_target      (cf_target),
        .cf_ack         (cf_ack),
        .imem_req       (imem_req),
        .imem_gnt       (imem_gnt),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_rdata (imem_rsp_rdata),
        .imem_rsp_error (imem_rsp_error),
        .buf_depth      (buf_depth),
        .buf_flush      (buf_flush),
        .buf_data       (buf_data),
        .buf_error      (buf_error),
        .buf_fill_2     (buf_fill_2),
        .buf_fill_4     (buf_fill_4),
        .buf_fill_6     (buf_fill_6),
        .buf_fill_8     (buf_fill_8)
    );

    typedef struct {
        bit          cf;
        logic [63:0] tgt;
        bit          gnt;
        bit          rv;
        logic [63:0] rd;
        bit          re;
        logic [4:0]  dep;
        bit          e_req;
        logic [63:0] e_addr;
        bit          e_ack;
        logic [3:0]  e_fill;
        logic [63:0] e_data;
        bit          e_err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic vec_t mk(bit cf, logic [63:0] tgt, bit gnt, bit rv, logic [63:0] rd, bit re,
                                int dep, bit e_req, logic [63:0] e_addr, bit e_ack,
                                logic [3:0] e_fill, logic [63:0] e_data, bit e_err);
        vec_t v;
        v.cf = cf; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rd = rd; v.re = re; v.dep = 5'(dep);
        v.e_req = e_req; v.e_addr = e_addr; v.e_ack = e_ack; v.e_fill = e_fill;
        v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %h, expected %h", tag, name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, compare mid-cycle, then step past the clock edge
    task automatic apply(input vec_t v, input string tag, input bit verbose);
        cf_req = v.cf; cf_target = v.tgt; imem_gnt = v.gnt; imem_rsp_valid = v.rv;
        imem_rsp_rdata = v.rd; imem_rsp_error = v.re; buf_depth = v.dep;
        #2;
        chk(tag, "imem_req", 64'(imem_req), 64'(v.e_req));
        if (v.e_req) chk(tag, "imem_addr", imem_addr, v.e_addr);
        chk(tag, "cf_ack", 64'(cf_ack), 64'(v.e_ack));
        chk(tag, "buf_flush", 64'(buf_flush), 64'(v.e_ack));
        chk(tag, "fill8642", 64'({buf_fill_8, buf_fill_6, buf_fill_4, buf_fill_2}), 64'(v.e_fill));
        chk(tag, "buf_data", buf_data, v.e_data);
        chk(tag, "buf_error", 64'(buf_error), 64'(v.e_err));
        if (verbose || v.e_fill != F0)
            $display("%s req=%0b addr=%h ack=%0b fill=%b data=%h err=%0b",
                     tag, imem_req, imem_addr, cf_ack,
                     {buf_fill_8, buf_fill_6, buf_fill_4, buf_fill_2}, buf_data, buf_error);
        @(posedge g_clk);
        #1;
    endtask

    // Reference model: fetch pointer, list of outstanding requests, pending and halt flags
    typedef struct { logic [1:0] off; bit disc; } ent_t;
    typedef struct { logic [63:0] addr; bit err; int ready; } mem_t;
    ent_t        mq[$];
    mem_t        memq[$];
    logic [63:0] m_ptr;
    bit          m_pend, m_halt, cf_hold;
    logic [63:0] cf_tgt_hold;

    function automatic int nb_of(logic [1:0] off);
        return 8 - 2 * int'(off);
    endfunction

    function automatic logic [63:0] memdata(logic [63:0] a);
        return {a[31:0] ^ 32'hC3A5_5A3C, a[31:0] * 32'h9E37_79B1};
    endfunction

    task automatic do_reset();
        g_resetn = 1'b0; cf_req = 1'b1; imem_gnt = 1'b1; imem_rsp_valid = 1'b0; buf_depth = '0;
        repeat (2) @(posedge g_clk);
        #2;
        chk("reset", "imem_req", 64'(imem_req), 64'd0);
        chk("reset", "cf_ack", 64'(cf_ack), 64'd0);
        chk("reset", "buf_flush", 64'(buf_flush), 64'd0);
        chk("reset", "fills", 64'({buf_fill_8, buf_fill_6, buf_fill_4, buf_fill_2}), 64'd0);
        chk("reset", "buf_data", buf_data, 64'd0);
        chk("reset", "buf_error", 64'(buf_error), 64'd0);
        $display("reset req=%0b ack=%0b flush=%0b", imem_req, cf_ack, buf_flush);
        @(posedge g_clk);
        #1;
        cf_req = 1'b0; imem_gnt = 1'b0;
        g_resetn = 1'b1;
        mq.delete(); memq.delete();
        m_ptr = PC; m_pend = 0; m_halt = 0; cf_hold = 0;
    endtask

    vec_t tbl[$];

    initial begin
        do_reset();

        // cf tgt gnt rv rd re dep | req addr ack fill data err
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0000, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 64'h0123_4567_89AB_CDEF, 0, 0,  0, 0, 0, F8, 64'h0123_4567_89AB_CDEF, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0008, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 64'h1111_2222_3333_4444, 0, 4,  0, 0, 0, F8, 64'h1111_2222_3333_4444, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6,  0, 0, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4,  1, 64'h8000_0010, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 12, 1, 64'h8000_0010, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 4,  1, 64'h8000_0010, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 0,  0, 0, 0, F8, 64'hAAAA_BBBB_CCCC_DDDD, 0));
        // redirect to an odd halfword with idle memory
        tbl.push_back(mk(1, 64'h8000_0106, 0, 0, 0, 0, 12, 0, 0, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0100, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 64'h1122_3344_5566_7788, 0, 0,  1, 64'h8000_0108, 0, F2, 64'h1122, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h5555_6666_7777_8888, 0, 12, 0, 0, 0, F8, 64'h5555_6666_7777_8888, 0));
        // two requests in flight, then redirect: both responses dropped
        tbl.push_back(mk(1, 64'h8000_0205, 0, 0, 0, 0, 12, 0, 0, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0200, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0208, 0, F0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0300, 0, 0, 0, 0, 0,  0, 0, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, JUNK, 0, 0,  0, 0, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0300, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, JUNK, 1, 0,  0, 0, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h9999_8888_7777_6666, 0, 12, 0, 0, 0, F8, 64'h9999_8888_7777_6666, 0));
        // redirect against a pending ungranted request
        tbl.push_back(mk(1, 64'h8000_0400, 0, 0, 0, 0, 0,  1, 64'h8000_0308, 0, F0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0400, 0, 0, 0, 0, 0,  1, 64'h8000_0308, 0, F0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0400, 0, 0, 0, 0, 0,  1, 64'h8000_0308, 0, F0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0400, 1, 0, 0, 0, 0,  1, 64'h8000_0308, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, JUNK, 0, 12, 0, 0, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0400, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'h0F0E_0D0C_0B0A_0908, 0, 12, 0, 0, 0, F8, 64'h0F0E_0D0C_0B0A_0908, 0));
        // error response, then halt or sequential continuation
        tbl.push_back(mk(1, 64'h8000_0010, 0, 0, 0, 0, 12, 0, 0, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0010, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 64'hDEAD_BEEF_CAFE_F00D, 1, 12, 0, 0, 0, F8, 64'hDEAD_BEEF_CAFE_F00D, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  !HALT_EN, 64'h8000_0018, 0, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  !HALT_EN, 64'h8000_0018, 0, F0, 0, 0));
        tbl.push_back(mk(1, 64'h8000_0500, 0, 0, 0, 0, 12, 0, 0, 1, F0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0,  1, 64'h8000_0500, 0, F0, 0, 0));

        for (int r = 0; r < tbl.size(); r++)
            apply(tbl[r], $sformatf("row%0d", r), 1'b1);

        // Random traffic against the reference model, with a reset part-way through
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            int   ib;
            bit   live, push;
            logic [1:0] m_off;

            if (i == 1500) do_reset();

            if (!cf_hold && ($urandom_range(0, 19) == 0)) begin
                cf_hold     = 1;
                cf_tgt_hold = {$urandom, $urandom};
            end
            v.cf  = cf_hold;
            v.tgt = cf_hold ? cf_tgt_hold : 64'd0;
            v.gnt = ($urandom_range(0, 9) < 7);
            v.dep = 5'($urandom_range(0, 12));
            v.rv  = (memq.size() > 0) && (memq[0].ready <= i) && ($urandom_range(0, 3) != 0);
            v.rd  = v.rv ? memdata(memq[0].addr) : {$urandom, $urandom};
            v.re  = v.rv ? memq[0].err : 1'b0;

            ib = 0;
            foreach (mq[k]) if (!mq[k].disc) ib += nb_of(mq[k].off);
            m_off   = m_ptr[2:1];
            v.e_req = m_pend || (mq.size() < 2 && int'(v.dep) + ib + nb_of(m_off) <= 12 && !m_halt);
            v.e_addr = {m_ptr[63:3], 3'b000};
            v.e_ack = v.cf && !(v.e_req && !v.gnt);
            live    = v.rv && !mq[0].disc && !v.e_ack;
            v.e_fill = F0;
            v.e_data = '0;
            v.e_err  = 0;
            if (live) begin
                v.e_fill = 4'(1 << (3 - int'(mq[0].off)));
                v.e_data = v.rd >> (16 * int'(mq[0].off));
                v.e_err  = v.re;
            end

            apply(v, $sformatf("rnd%0d", i), 1'b0);

            push = v.e_req && v.gnt;
            if (v.rv) begin
                void'(mq.pop_front());
                void'(memq.pop_front());
            end
            if (push) begin
                mq.push_back('{off: m_off, disc: 1'b0});
                memq.push_back('{addr: v.e_addr, err: ($urandom_range(0, 7) == 0),
                                 ready: i + 1 + int'($urandom_range(0, 2))});
            end
            if (v.e_ack) begin
                foreach (mq[k]) mq[k].disc = 1'b1;
                m_ptr   = {v.tgt[63:1], 1'b0};
                m_halt  = 0;
                cf_hold = 0;
            end else begin
                if (push) m_ptr = v.e_addr + 64'd8;
                if (live && v.re && HALT_EN) m_halt = 1;
            end
            m_pend = v.e_req && !v.gnt;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_pipe_fetch_req.md
Name: core_pipe_fetch_req

Overview:
- Front end of the fetch stage, directly upstream of the fetch data buffer.
- Issues 64-bit aligned instruction memory requests from a fetch pointer and aligns each response to the current halfword offset.
- Drives the buffer's data_in, error_in, fill_2/4/6/8 and flush inputs.
- Throttles requests against buffer depth plus bytes in flight, and handles control-flow redirects, including discard of stale responses.

Parameters:
- PC_RESET, 64'h0000_0000_8000_0000, fetch address after reset.
- BUF_BYTES, 12, capacity of the downstream buffer in bytes.
- MAX_INFLIGHT, 2, maximum granted-but-unanswered memory requests.

Ports:
- g_clk  in  1  global clock
- g_resetn  in  1  global reset
- cf_req  in  1  control-flow change request
- cf_target  in  64  redirect target, bit 0 ignored
- cf_ack  out  1  redirect accepted this cycle
- imem_req  out  1  memory request valid
- imem_gnt  in  1  memory request granted
- imem_addr  out  64  request address, [2:0] always 0
- imem_rsp_valid  in  1  response valid
- imem_rsp_rdata  in  64  response data
- imem_rsp_error  in  1  response bus error
- buf_depth  in  5  current buffer depth in bytes
- buf_flush  out  1  flush the buffer
- buf_data  out  64  aligned data to the buffer
- buf_error  out  1  error tag to the buffer
- buf_fill_2, buf_fill_4, buf_fill_6, buf_fill_8  out  1 each  one-hot fill size, or all zero

Behaviour:
- Clock g_clk; reset g_resetn, synchronous, active-low.
- Reset values:
  - imem_req=0, cf_ack=0, buf_flush=0, all fills=0, buf_data=0, buf_error=0.
  - fetch_ptr=PC_RESET, inflight count=0, inflight_bytes=0.
- Fetch pointer:
  - fetch_ptr is a registered byte address; off=fetch_ptr[2:1]; imem_addr={fetch_ptr[63:3],3'b0}.
  - Request size nb=8-2*off (8, 6, 4 or 2 bytes).
- Issue condition: imem_req=1 when inflight<MAX_INFLIGHT AND buf_depth+inflight_bytes+nb<=BUF_BYTES (7-bit arithmetic, no overflow).
- Request handshake:
  - Once imem_req=1, imem_req and imem_addr hold stable until imem_gnt; no retraction.
  - On gnt: push {off, discard=0} into the inflight tracker; inflight_bytes+=nb; fetch_ptr=(imem_addr+8).
- Responses are in order, one per grant, earliest the cycle after gnt. On imem_rsp_valid, pop the tracker head:
  - discard=1: drop the response; no fill; inflight_bytes unchanged, since it was zeroed at redirect.
  - discard=0: buf_data=rdata>>(16*off), zero-filled; buf_error=imem_rsp_error; assert the fill matching 8-2*off (off0->fill_8, 1->fill_6, 2->fill_4, 3->fill_2); inflight_bytes-=nb.
  - Fill outputs are combinational from the response; zero latency into the buffer.
- Simultaneous gnt and rsp in the same cycle: push and pop both apply; inflight count unchanged; inflight_bytes net of both.
- Redirect:
  - cf_ack=cf_req AND NOT(imem_req AND NOT imem_gnt). A pending ungranted request completes first; cf_req must hold until cf_ack.
  - In the cf_ack cycle:
    - buf_flush=1 for exactly one cycle.
    - fetch_ptr=cf_target with bit0 cleared.
    - All tracker entries, including one pushed by a gnt in the same cycle, get discard=1.
    - inflight_bytes=0.
    - Any response arriving that cycle is treated as discard, so no fill is asserted.
  - The next request may issue the following cycle. inflight does not decrement until discards return, so MAX_INFLIGHT still bounds outstanding traffic.
- Back-to-back redirects are each acked independently; already-discarded entries stay discarded.
- A response with the tracker empty is illegal and assertion-checked in simulation.
- A reset mid-transaction clears all state. The memory side must also be reset, so no stale responses are expected.

Optional Feature:
- CORE_FETCH_ERR_HALT_EN
  - Defined: after accepting a non-discarded response with imem_rsp_error=1, set a halt flag. While the flag is set, imem_req=0. The flag clears only on cf_ack or reset.
  - Undefined: fetch continues sequentially after errors; errors are only tagged via buf_error.

Decomposition:
- core_common.vh gains:
  - constant FETCH_BUF_BYTES=12, shared with the buffer.
  - FETCH_OFF_W=2.
  - An inflight-entry field layout: {discard, off[1:0]}.
- Sub-module core_pipe_fetch_req_fifo: MAX_INFLIGHT-entry in-order tracker with push, pop, and mark-all-discard ports, plus a count output.

Test Plan:
- Reset with PC_RESET=0x80000000, gnt tied 1, 1-cycle rsp, buf_depth=0 -> first imem_addr=0x80000000, fill_8 with rdata unshifted; second request 0x80000008. Third is held until buf_depth+inflight_bytes+8<=12.
- Redirect to 0x80000106 with idle memory -> buf_flush pulse; next imem_addr=0x80000100; response 0x1122334455667788 gives buf_data=0x0000000000001122, fill_2; following request 0x80000108 gives fill_8.
- Redirect while 2 requests are in flight -> both responses are dropped (no fill); the new target's data is the first fill; MAX_INFLIGHT is never exceeded.
- cf_req while imem_req=1 and gnt=0 for 3 cycles -> imem_addr stable; cf_ack only in the gnt cycle; the granted request's response is discarded.
- buf_depth=6, inflight_bytes=0, off=0 -> imem_req=0; buf_depth drops to 4 -> imem_req=1 the same cycle.
- Error response at 0x80000010 -> buf_error=1 with fill_8. With CORE_FETCH_ERR_HALT_EN defined: imem_req stays 0 until a redirect, then resumes. Without it: the 0x80000018 request issues.
